// File: rtl/alu_execute.sv
// Registered 16-bit execute-stage ALU with a serial shifter and start/busy/done handshake.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shift.
module alu_execute #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_SHIFT = 3'd6;
    localparam logic [2:0] OP_SLT   = 3'd7;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = A + B;
    assign diff = A - B;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Op)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: alu_res = ($signed(A) < $signed(B)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
`ifdef ALU_FAST_SHIFT_EN
            OP_SHIFT: begin
                if (!B[6])
                    alu_res = A << B[3:0];
                else if (B[5])
                    alu_res = A >> B[3:0];
                else
                    alu_res = $signed(A) >>> B[3:0];
            end
`else
            // Only reached with a zero shift amount; longer shifts run serially.
            OP_SHIFT: alu_res = A;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN

    assign busy = 1'b0;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            done     <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                Result   <= alu_res;
                Zero     <= (alu_res == '0);
                Overflow <= alu_ovf;
                done     <= 1'b1;
            end
        end
    end

`else

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_reg;
    logic [3:0]       count;
    logic             sh_right;
    logic             sh_logical;
    logic [WIDTH-1:0] sh_next;

    // Left shifts always fill with zero; right shifts fill per the logical/arithmetic bit.
    always_comb begin
        if (!sh_right)
            sh_next = {sh_reg[WIDTH-2:0], 1'b0};
        else if (sh_logical)
            sh_next = {1'b0, sh_reg[WIDTH-1:1]};
        else
            sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    end

    assign busy = (state == SHIFT);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sh_reg     <= '0;
            count      <= '0;
            sh_right   <= 1'b0;
            sh_logical <= 1'b0;
            done       <= 1'b0;
            Result     <= '0;
            Zero       <= 1'b1;
            Overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (Op == OP_SHIFT && B[3:0] != 4'd0) begin
                            sh_reg     <= A;
                            count      <= B[3:0];
                            sh_right   <= B[6];
                            sh_logical <= B[5];
                            state      <= SHIFT;
                        end else begin
                            Result   <= alu_res;
                            Zero     <= (alu_res == '0);
                            Overflow <= alu_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sh_reg <= sh_next;
                    count  <= count - 4'd1;
                    if (count == 4'd1) begin
                        Result   <= sh_next;
                        Zero     <= (sh_next == '0);
                        Overflow <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: doc/alu_execute.md
# alu_execute

Registered 16-bit execute-stage ALU sitting directly downstream of the ALU control decoder: it consumes the 3-bit ALU opcode and the conditioned B operand (shift control already folded into B), plus operand A from the register file. It performs AND/OR/ADD/SUB/SHIFT/SLT, with shifts done serially one bit per cycle. A start/busy/done handshake lets the multicycle controller stall while a shift is in flight.

## Interface
Parameters:
- WIDTH, 16, datapath width; only 16 is supported.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one operation; sampled only when busy=0.
- Op  input  3  opcode: 0 AND, 2 OR, 4 ADD, 5 SUB, 6 SHIFT, 7 SLT; 1 and 3 reserved.
- A  input  16  operand A.
- B  input  16  operand B. For SHIFT: B[3:0] amount, B[6]=1 right/0 left, B[5]=1 logical/0 arithmetic (right only).
- busy  output  1  operation in flight; start ignored while high.
- done  output  1  one-cycle pulse; Result/Zero/Overflow valid from this cycle on.
- Result  output  16  registered result, held until the next done.
- Zero  output  1  Result==0, registered with Result.
- Overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- States: IDLE, SHIFT.
- IDLE, start=1, Op≠6: compute combinationally, register Result/Zero/Overflow, pulse done; stay IDLE.
- IDLE, start=1, Op=6, N=B[3:0]:
  - N=0: Result=A, done pulses; stay IDLE.
  - N>0: latch A into a shift register, count=N and the direction/mode bits; go to SHIFT.
- SHIFT: one-bit shift per edge, count decrements. When the edge performing the last shift occurs (count 1→0), register Result, pulse done and return to IDLE.
- Shift fill:
  - Left: 0 into bit 0. B[5] is ignored.
  - Right logical: 0 into bit 15.
  - Right arithmetic: bit 15 replicated.
- ADD/SUB: modulo 2^16. Overflow = operand signs agree (B inverted for SUB) and result sign differs.
- SLT: signed compare; Result = 16'h0001 if A<B, else 16'h0000.
- Reserved ops 1, 3: Result=0, Zero=1, Overflow=0, done pulses normally.
- A, B and Op are sampled only at the accepting edge. Changes during SHIFT have no effect.
- busy = (state==SHIFT).

## Timing
- Reset: state IDLE; busy=0, done=0, Result=0, Zero=1, Overflow=0. Reset mid-SHIFT aborts the op with no done.
- Non-shift op or N=0: start accepted at edge k → done high and Result valid in cycle k+1 (latency 1).
- Shift with N≥1: accepted at edge k; shifts at edges k+1…k+N; done high in cycle k+N+1 (latency N+1). busy is high in cycles k+1…k+N.
- done is high for exactly one cycle. Since busy=0 during the done cycle, a start in that cycle is accepted (back-to-back issue).
- start while busy=1: ignored, not queued.
- reset and start in the same cycle: reset wins.

## Configuration
- ALU_FAST_SHIFT_EN defined:
  - SHIFT is a single-cycle barrel shift with latency 1 for any N.
  - SHIFT state unused; busy is tied to 0.
- Undefined: serial shifter as described above.
- Result values are identical in both builds; only latency and busy differ.

## Test plan
- Reset: assert reset for 2 cycles mid-shift (A=16'h8000, B=16'h004F) → busy=0, done never pulses, Result=0, Zero=1.
- ADD overflow: Op=4, A=16'h7FFF, B=16'h0001 → next cycle done=1, Result=16'h8000, Overflow=1, Zero=0. Then Op=5, A=B=16'h1234 → Result=0, Zero=1.
- SLT signed: Op=7, A=16'hFFFF, B=16'h0001 → Result=16'h0001. Swap operands → 16'h0000.
- Serial SRA: Op=6, A=16'h8000, B=16'h0044 → busy for 4 cycles, done in cycle 5 after start, Result=16'hF800. With ALU_FAST_SHIFT_EN: done in cycle 1, same Result.
- SRL/SLL/N=0:
  - B=16'h0061, A=16'h8001 → 16'h4000.
  - B=16'h000F, A=16'h0001 → 16'h8000, latency 16.
  - B=16'h0060 → Result=A, latency 1.
- Handshake: start held high throughout a 3-bit shift → the second op is accepted exactly in the done cycle; pulses during busy produce no extra done.
